// File: rtl/stage_if.sv
// Instruction-fetch stage: owns the architectural PC, runs a single-outstanding
// request/ready transaction with instruction memory, and feeds the IF/ID register.
module stage_if #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        br_i,
  input  logic [31:0] br_target_i,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_data_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        stall_req_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc_r, pc_n;
  logic        discard, discard_n;
  logic [31:0] buf_r, buf_n;
  logic        buf_valid, buf_valid_n;
  logic        req_n;
  logic [31:0] addr_n;
  logic [31:0] pc_o_n;
  logic [31:0] inst_n;
  logic        valid_n;

  logic [31:0] br_tgt;
  logic [31:0] pc_inc;
  logic        unused_br_lsb;

  assign br_tgt        = {br_target_i[31:2], 2'b00};
  assign pc_inc        = pc_r + 32'd4;
  assign unused_br_lsb = ^br_target_i[1:0];

  // Memory stall request: waiting on an outstanding fetch that has not returned.
  assign stall_req_o = (state == S_WAIT) && !mem_ready_i;

  // Next-state, request and IF/ID output logic.
  always_comb begin
    state_n     = state;
    pc_n        = pc_r;
    discard_n   = discard;
    buf_n       = buf_r;
    buf_valid_n = buf_valid;
    req_n       = mem_req_o;
    addr_n      = mem_addr_o;
    pc_o_n      = pc_o;
    inst_n      = inst_o;
    valid_n     = inst_valid_o;

    // A redirect always flushes IF/ID; otherwise an unstalled edge with no
    // delivery inserts a bubble. Deliveries below override this.
    if (br_i || !stall_i) begin
      inst_n  = NOP_INST;
      valid_n = 1'b0;
    end

    case (state)
      S_FETCH: begin
        req_n   = 1'b1;
        state_n = S_WAIT;
        if (br_i) begin
          pc_n   = br_tgt;
          addr_n = br_tgt;
        end else begin
          addr_n = pc_r;
        end
      end

      S_WAIT: begin
        if (br_i) begin
          pc_n = br_tgt;
          if (mem_ready_i) begin
            // Returned word is stale; restart at the target on this same edge.
            discard_n = 1'b0;
            req_n     = 1'b1;
            addr_n    = br_tgt;
          end else begin
            discard_n = 1'b1;
          end
        end else if (mem_ready_i) begin
          if (discard) begin
            discard_n = 1'b0;
            req_n     = 1'b1;
            addr_n    = pc_r;
          end else if (stall_i) begin
            buf_n       = mem_data_i;
            buf_valid_n = 1'b1;
            req_n       = 1'b0;
            state_n     = S_HOLD;
          end else begin
            inst_n  = mem_data_i;
            pc_o_n  = pc_r;
            valid_n = 1'b1;
            pc_n    = pc_inc;
            req_n   = 1'b1;
            addr_n  = pc_inc;
          end
        end
      end

      S_HOLD: begin
        if (br_i) begin
          buf_valid_n = 1'b0;
          pc_n        = br_tgt;
          req_n       = 1'b1;
          addr_n      = br_tgt;
          state_n     = S_WAIT;
        end else if (!stall_i) begin
          // pc_r was not advanced at capture, so it is the buffered word's PC.
          inst_n      = buf_r;
          pc_o_n      = pc_r;
          valid_n     = buf_valid;
          buf_valid_n = 1'b0;
          pc_n        = pc_inc;
          req_n       = 1'b1;
          addr_n      = pc_inc;
          state_n     = S_WAIT;
        end
      end

      default: begin
        state_n = S_FETCH;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_FETCH;
      pc_r         <= RESET_PC;
      discard      <= 1'b0;
      buf_r        <= '0;
      buf_valid    <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= '0;
      pc_o         <= '0;
      inst_o       <= NOP_INST;
      inst_valid_o <= 1'b0;
    end else begin
      state        <= state_n;
      pc_r         <= pc_n;
      discard      <= discard_n;
      buf_r        <= buf_n;
      buf_valid    <= buf_valid_n;
      mem_req_o    <= req_n;
      mem_addr_o   <= addr_n;
      pc_o         <= pc_o_n;
      inst_o       <= inst_n;
      inst_valid_o <= valid_n;
    end
  end

endmodule

// File: tb/tb_stage_if.sv
// Directed self-checking bench for the instruction-fetch stage.
module tb_stage_if;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] K   = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        br_i;
  logic [31:0] br_target_i;
  logic        mem_ready_i;
  logic [31:0] mem_data_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        stall_req_o;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  stage_if #(
    .RESET_PC(32'h00000000),
    .NOP_INST(32'h00000013)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .br_i        (br_i),
    .br_target_i (br_target_i),
    .mem_ready_i (mem_ready_i),
    .mem_data_i  (mem_data_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .pc_o        (pc_o),
    .inst_o      (inst_o),
    .inst_valid_o(inst_valid_o),
    .stall_req_o (stall_req_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory returns addr^K for whatever address is currently requested.
  task automatic mem_tick();
    mem_data_i = mem_addr_o ^ K;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; stall_i = 1'b0; br_i = 1'b0; br_target_i = '0;
    mem_ready_i = 1'b0; mem_data_i = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (mem_req_o !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b exp 0", mem_req_o); end
    vectors++; if (mem_addr_o !== 32'h0) begin miscompares++; $display("FAIL reset_addr got %h exp 0", mem_addr_o); end
    vectors++; if (pc_o !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h exp 0", pc_o); end
    vectors++; if (inst_o !== NOP) begin miscompares++; $display("FAIL reset_inst got %h exp %h", inst_o, NOP); end
    vectors++; if (inst_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", inst_valid_o); end
    vectors++; if (stall_req_o !== 1'b0) begin miscompares++; $display("FAIL reset_stallreq got %b exp 0", stall_req_o); end
  endtask

  task automatic test_stream();
    do_reset();
    mem_ready_i = 1'b1;
    mem_tick();
    vectors++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin miscompares++; $display("FAIL stream_first_req got %b/%h exp 1/0", mem_req_o, mem_addr_o); end
    vectors++; if (inst_valid_o !== 1'b0) begin miscompares++; $display("FAIL stream_first_valid got %b exp 0", inst_valid_o); end
    for (int k = 0; k < 6; k++) begin
      mem_tick();
      vectors++; if (pc_o !== 32'(4*k)) begin miscompares++; $display("FAIL stream_pc k=%0d got %h exp %h", k, pc_o, 32'(4*k)); end
      vectors++; if (inst_o !== (32'(4*k) ^ K)) begin miscompares++; $display("FAIL stream_inst k=%0d got %h exp %h", k, inst_o, 32'(4*k) ^ K); end
      vectors++; if (inst_valid_o !== 1'b1) begin miscompares++; $display("FAIL stream_valid k=%0d got %b exp 1", k, inst_valid_o); end
      vectors++; if (mem_addr_o !== 32'(4*k+4) || mem_req_o !== 1'b1) begin miscompares++; $display("FAIL stream_addr k=%0d got %b/%h exp 1/%h", k, mem_req_o, mem_addr_o, 32'(4*k+4)); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    mem_ready_i = 1'b1;
    mem_tick(); mem_tick(); mem_tick();   // req 0; deliver 0; deliver 4, request 8
    stall_i = 1'b1;
    mem_tick();                           // word at 0x8 captured into hold buffer
    for (int c = 0; c < 3; c++) begin
      vectors++; if (pc_o !== 32'h4 || inst_o !== (32'h4 ^ K) || inst_valid_o !== 1'b1) begin
        miscompares++; $display("FAIL stall_hold c=%0d got %h/%h/%b exp 4/%h/1", c, pc_o, inst_o, inst_valid_o, 32'h4 ^ K); end
      vectors++; if (mem_req_o !== 1'b0 || stall_req_o !== 1'b0) begin
        miscompares++; $display("FAIL stall_noreq c=%0d got req %b sreq %b exp 0 0", c, mem_req_o, stall_req_o); end
      mem_data_i = 32'hDEADBEEF;
      if (c < 2) tick();
    end
    stall_i = 1'b0;
    tick();
    vectors++; if (pc_o !== 32'h8 || inst_o !== (32'h8 ^ K) || inst_valid_o !== 1'b1) begin
      miscompares++; $display("FAIL stall_release got %h/%h/%b exp 8/%h/1", pc_o, inst_o, inst_valid_o, 32'h8 ^ K); end
    vectors++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'hC) begin
      miscompares++; $display("FAIL stall_nextreq got %b/%h exp 1/c", mem_req_o, mem_addr_o); end
    mem_tick();
    vectors++; if (pc_o !== 32'hC || inst_o !== (32'hC ^ K)) begin
      miscompares++; $display("FAIL stall_after got %h/%h exp c/%h", pc_o, inst_o, 32'hC ^ K); end
  endtask

  task automatic test_branch_wait();
    do_reset();
    mem_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) mem_tick();   // request to 0x10 now outstanding
    mem_ready_i = 1'b0; br_i = 1'b1; br_target_i = 32'h103;
    #1;
    vectors++; if (stall_req_o !== 1'b1) begin miscompares++; $display("FAIL br_stallreq got %b exp 1", stall_req_o); end
    mem_tick();
    br_i = 1'b0;
    vectors++; if (inst_valid_o !== 1'b0 || inst_o !== NOP) begin
      miscompares++; $display("FAIL br_flush got %b/%h exp 0/%h", inst_valid_o, inst_o, NOP); end
    vectors++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h10) begin
      miscompares++; $display("FAIL br_holdreq got %b/%h exp 1/10", mem_req_o, mem_addr_o); end
    mem_tick(); mem_tick(); mem_tick();
    mem_ready_i = 1'b1;
    mem_tick();                           // stale 0x10 word returns
    vectors++; if (inst_valid_o !== 1'b0 || mem_addr_o !== 32'h100) begin
      miscompares++; $display("FAIL br_discard got %b/%h exp 0/100", inst_valid_o, mem_addr_o); end
    mem_tick();
    vectors++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h100 || inst_o !== (32'h100 ^ K)) begin
      miscompares++; $display("FAIL br_target_inst got %b/%h/%h exp 1/100/%h", inst_valid_o, pc_o, inst_o, 32'h100 ^ K); end
    vectors++; if (mem_addr_o !== 32'h104) begin miscompares++; $display("FAIL br_next_addr got %h exp 104", mem_addr_o); end
  endtask

  task automatic test_br_ready_stall();
    do_reset();
    mem_ready_i = 1'b1;
    mem_tick(); mem_tick();               // 0 delivered, request 4 outstanding
    stall_i = 1'b1; br_i = 1'b1; br_target_i = 32'h20000042;
    mem_tick();
    stall_i = 1'b0; br_i = 1'b0;
    vectors++; if (inst_valid_o !== 1'b0 || inst_o !== NOP || pc_o !== 32'h0) begin
      miscompares++; $display("FAIL brs_flush got %b/%h/%h exp 0/%h/0", inst_valid_o, inst_o, pc_o, NOP); end
    vectors++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h20000040) begin
      miscompares++; $display("FAIL brs_target got %b/%h exp 1/20000040", mem_req_o, mem_addr_o); end
    mem_tick();
    vectors++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h20000040 || inst_o !== (32'h20000040 ^ K)) begin
      miscompares++; $display("FAIL brs_deliver got %b/%h/%h exp 1/20000040/%h", inst_valid_o, pc_o, inst_o, 32'h20000040 ^ K); end
  endtask

  task automatic test_wrap();
    do_reset();
    mem_ready_i = 1'b1; br_i = 1'b1; br_target_i = 32'hFFFFFFFF;
    mem_tick();                           // redirect taken from FETCH
    br_i = 1'b0;
    vectors++; if (mem_addr_o !== 32'hFFFFFFFC) begin miscompares++; $display("FAIL wrap_req got %h exp fffffffc", mem_addr_o); end
    mem_tick();
    vectors++; if (pc_o !== 32'hFFFFFFFC || inst_o !== 32'h5A5A5A59) begin
      miscompares++; $display("FAIL wrap_deliver got %h/%h exp fffffffc/5a5a5a59", pc_o, inst_o); end
    vectors++; if (mem_addr_o !== 32'h0) begin miscompares++; $display("FAIL wrap_addr got %h exp 0", mem_addr_o); end
    mem_tick();
    vectors++; if (pc_o !== 32'h0 || inst_o !== K || mem_addr_o !== 32'h4) begin
      miscompares++; $display("FAIL wrap_after got %h/%h/%h exp 0/%h/4", pc_o, inst_o, mem_addr_o, K); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_ready_i = 1'b1;
    mem_tick(); mem_tick();               // 0 delivered, request 4 outstanding
    mem_ready_i = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0 || inst_valid_o !== 1'b0 || inst_o !== NOP || pc_o !== 32'h0) begin
      miscompares++; $display("FAIL rstmid_async got %b/%h/%b/%h/%h exp 0/0/0/%h/0", mem_req_o, mem_addr_o, inst_valid_o, inst_o, pc_o, NOP); end
    mem_ready_i = 1'b1; mem_data_i = 32'hCAFEF00D;
    tick();
    rst = 1'b0;
    vectors++; if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_stray got %b/%b exp 0/0", inst_valid_o, mem_req_o); end
    tick();
    vectors++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0 || inst_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_first got %b/%h/%b exp 1/0/0", mem_req_o, mem_addr_o, inst_valid_o); end
    mem_ready_i = 1'b0;
    #1;
    vectors++; if (stall_req_o !== 1'b1) begin miscompares++; $display("FAIL rstmid_stallreq got %b exp 1", stall_req_o); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch_wait();
    test_br_ready_stall();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
